param_updown_counter: RTL and testbench

- Parametrised synchronous up/down counter with a programmable modulus, enable, parallel load, and wrap or saturate selection.
- Provides a terminal-count output for cascading and sticky overflow/underflow flags.
- It is the general-purpose successor to the fixed 4-bit up/down counter and is used for event counting, timers and decade/modulo chains.

---
 rtl/param_updown_counter.sv | 76 +++++++
 tb/tb_param_updown_counter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with programmable modulus (0..MAX_VAL),
// parallel load with clamp, wrap/saturate boundary handling, a
// combinational terminal count for cascading, and sticky overflow/underflow flags.
module param_updown_counter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = (2**WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             sat,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             udf
);

  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO_Q = '0;

  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] q_next;
  logic             ovf_next;
  logic             udf_next;

  assign at_max = (q == MAX_Q);
  assign at_min = (q == ZERO_Q);

  // Terminal count stays unregistered so a following stage can use it as its enable.
  assign tc = en & (mode ? at_max : at_min);

  // Next count and flag values; load outranks counting, a new event outranks a flag clear.
  always_comb begin
    q_next   = q;
    ovf_next = ovf & ~clr_flags;
    udf_next = udf & ~clr_flags;
    if (load) begin
      q_next = (d > MAX_Q) ? MAX_Q : d;
    end else if (en) begin
      if (mode) begin
        if (at_max) begin
          q_next   = sat ? MAX_Q : ZERO_Q;
          ovf_next = 1'b1;
        end else begin
          q_next = q + WIDTH'(1);
        end
      end else begin
        if (at_min) begin
          q_next   = sat ? ZERO_Q : MAX_Q;
          udf_next = 1'b1;
        end else begin
          q_next = q - WIDTH'(1);
        end
      end
    end
  end

  // Count and flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q   <= ZERO_Q;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      q   <= q_next;
      ovf <= ovf_next;
      udf <= udf_next;
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter (WIDTH=4, MAX_VAL=9): a cycle model
// checked every cycle on the falling edge, plus hand-computed literal checks.
module tb_param_updown_counter;

  localparam int unsigned W    = 4;
  localparam int unsigned MAXV = 9;

  logic         clk;
  logic         rst;
  logic         en;
  logic         mode;
  logic         load;
  logic [W-1:0] d;
  logic         sat;
  logic         clr_flags;
  logic [W-1:0] q;
  logic         tc;
  logic         ovf;
  logic         udf;

  int vectors;
  int miscompares;

  // Behavioural model state
  int m_q;
  bit m_ovf;
  bit m_udf;
  bit m_valid;

  param_updown_counter #(.WIDTH(W), .MAX_VAL(MAXV)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .d(d),
    .sat(sat), .clr_flags(clr_flags), .q(q), .tc(tc), .ovf(ovf), .udf(udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: next count from the rules in modular arithmetic terms.
  always @(posedge clk) begin
    if (rst === 1'b0) begin
      m_q = 0; m_ovf = 0; m_udf = 0; m_valid = 1;
    end else if (m_valid) begin
      if (clr_flags) begin m_ovf = 0; m_udf = 0; end
      if (load) begin
        m_q = (int'(d) > MAXV) ? MAXV : int'(d);
      end else if (en) begin
        if (mode) begin
          if (m_q == MAXV) begin
            m_ovf = 1;
            m_q = sat ? MAXV : 0;
          end else m_q = (m_q + 1) % (MAXV + 1);
        end else begin
          if (m_q == 0) begin
            m_udf = 1;
            m_q = sat ? 0 : MAXV;
          end else m_q = (m_q + MAXV) % (MAXV + 1);
        end
      end
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_q",   int'(q),   m_q);
      chk("model_ovf", int'(ovf), int'(m_ovf));
      chk("model_udf", int'(udf), int'(m_udf));
      chk("model_tc",  int'(tc),  int'(en & (mode ? (m_q == MAXV) : (m_q == 0))));
    end
  end

  // Apply one cycle of inputs, then return just after the consuming edge.
  task automatic cyc(input logic r, input logic e, input logic m, input logic l,
                     input logic [W-1:0] dv, input logic s, input logic c);
    rst = r; en = e; mode = m; load = l; d = dv; sat = s; clr_flags = c;
    @(posedge clk);
    #1;
  endtask

  int up_exp [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int dn_exp [4]  = '{9, 8, 7, 6};

  initial begin
    vectors = 0; miscompares = 0; m_valid = 0; m_q = 0; m_ovf = 0; m_udf = 0;

    // Reset with other inputs active
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
    chk("rst_q", int'(q), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_udf", int'(udf), 0);
    chk("rst_tc_down_en", int'(tc), 1);

    // Wrap-around up count
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("up_q", int'(q), up_exp[i]);
      chk("up_tc", int'(tc), (up_exp[i] == 9) ? 1 : 0);
      chk("up_ovf", int'(ovf), (i >= 9) ? 1 : 0);
    end

    // Load 0 while clearing flags, then wrap-around down count
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    chk("ld0_q", int'(q), 0);
    chk("ld0_ovf", int'(ovf), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("dn_q", int'(q), dn_exp[i]);
      chk("dn_udf", int'(udf), 1);
    end

    // Saturating up from 8
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0);
    chk("sat_ld8", int'(q), 8);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    chk("sat_up_q", int'(q), 9);
    chk("sat_up_ovf", int'(ovf), 1);
    chk("sat_up_tc", int'(tc), 1);

    // Saturating down from 1
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
    chk("sat_ld1", int'(q), 1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    chk("sat_dn_q", int'(q), 0);
    chk("sat_dn_udf", int'(udf), 1);

    // Load clamp, load beats enable, hold with en=0
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'd15, 1'b0, 1'b0);
    chk("ld_clamp", int'(q), 9);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'd10, 1'b0, 1'b0);
    chk("ld_clamp10", int'(q), 9);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
    chk("ld_over_en", int'(q), 3);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("hold_q", int'(q), 3);
      chk("hold_tc", int'(tc), 0);
    end

    // Flag clear at q=3, then clear coinciding with a new overflow
    chk("pre_clr_ovf", int'(ovf), 1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    chk("clr_ovf", int'(ovf), 0);
    chk("clr_udf", int'(udf), 0);
    chk("clr_q", int'(q), 3);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0);
    chk("ld9_ovf", int'(ovf), 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    chk("set_wins_q", int'(q), 0);
    chk("set_wins_ovf", int'(ovf), 1);

    // Reset mid-count overrides load/en, then resume from 0
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
    chk("mid_ld5", int'(q), 5);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0);
    chk("mid_rst_q", int'(q), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    chk("mid_rst_udf", int'(udf), 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("resume_q", int'(q), 1);

    // Direction change with no turnaround cycle
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("turn_q", int'(q), 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("turn_back_q", int'(q), 1);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
